// File: rtl/pcie_ram_loader.sv
// Unpacks PCIe-width stream beats into WORD_W words and writes them to consecutive RAM addresses.
// Latency: beat accepted at A writes lane k at A+1+k; done pulses one cycle after the last write.
// Backpressure: s_ready is high only in ACCEPT, so throughput is one beat per LANES+1 cycles.
module pcie_ram_loader #(
    parameter int PCIE_W = 64,
    parameter int WORD_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     word_count,
    input  logic                s_valid,
    input  logic [PCIE_W-1:0]   s_data,
    output logic                s_ready,
    output logic                ram_en,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [WORD_W-1:0]   ram_din,
    output logic                busy,
    output logic                done
);

    localparam int LANES  = PCIE_W / WORD_W;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

    state_t                         state_q, state_d;
    logic [LANES-1:0][WORD_W-1:0]   beat_q, beat_d;
    logic [LANE_W-1:0]              lane_q, lane_d;
    logic [ADDR_W:0]                idx_q, idx_d;
    logic [ADDR_W:0]                count_q, count_d;
    logic [ADDR_W-1:0]              base_q, base_d;

    logic                           s_ready_q, s_ready_d;
    logic                           ram_en_q, ram_en_d;
    logic [ADDR_W-1:0]              ram_addr_q, ram_addr_d;
    logic [WORD_W-1:0]              ram_din_q, ram_din_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        lane_d  = lane_q;
        idx_d   = idx_q;
        count_d = count_q;
        base_d  = base_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    count_d = word_count;
                    idx_d   = '0;
                    state_d = (word_count == '0) ? DONE : ACCEPT;
                end
            end
            ACCEPT: begin
                if (s_valid && s_ready_q) begin
                    beat_d  = s_data;
                    lane_d  = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                idx_d  = idx_q + 1'b1;
                lane_d = lane_q + 1'b1;
                // Count check wins over the lane check so a partial final beat ends the load.
                if (idx_d == count_q) begin
                    state_d = DONE;
                end else if (lane_q == LAST_LANE) begin
                    state_d = ACCEPT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are precomputed from the next state so they are registered yet cycle-accurate.
        s_ready_d  = (state_d == ACCEPT);
        busy_d     = (state_d == ACCEPT) || (state_d == WRITE);
        done_d     = (state_d == DONE);
        ram_en_d   = (state_d == WRITE);
        ram_addr_d = '0;
        ram_din_d  = '0;
        if (state_d == WRITE) begin
            ram_addr_d = base_d + idx_d[ADDR_W-1:0];
            ram_din_d  = beat_d[lane_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            lane_q     <= '0;
            idx_q      <= '0;
            count_q    <= '0;
            base_q     <= '0;
            s_ready_q  <= 1'b0;
            ram_en_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            lane_q     <= lane_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            base_q     <= base_d;
            s_ready_q  <= s_ready_d;
            ram_en_q   <= ram_en_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign s_ready  = s_ready_q;
    assign ram_en   = ram_en_q;
    assign ram_we   = ram_en_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_pcie_ram_loader.sv
// Self-checking bench for pcie_ram_loader: directed loads plus randomized loads against a word-list model.
module tb_pcie_ram_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [16:0] word_count;
    logic        s_valid;
    logic [63:0] s_data;
    logic        s_ready;
    logic        ram_en;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [15:0] ram_din;
    logic        busy;
    logic        done;

    pcie_ram_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records every write and every output cycle count on the falling edge.
    logic [15:0] wr_addr[$];
    logic [15:0] wr_data[$];
    int          wr_cyc[$];
    int          done_cyc[$];
    int          rdy_cnt = 0;
    int          busy_cnt = 0;
    int          en_mis = 0;

    always @(negedge clk) begin
        if (ram_we) begin
            wr_addr.push_back(ram_addr);
            wr_data.push_back(ram_din);
            wr_cyc.push_back(cyc);
        end
        if (done) done_cyc.push_back(cyc);
        if (s_ready) rdy_cnt++;
        if (busy) busy_cnt++;
        if (ram_en !== ram_we) en_mis++;
    end

    logic [63:0] beats[$];
    int          gaps[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_beats(input int nb);
        beats.delete();
        gaps.delete();
        for (int b = 0; b < nb; b++) begin
            beats.push_back({$urandom, $urandom});
            gaps.push_back(int'($urandom_range(0, 3)));
        end
    endtask

    // Runs one load using beats/gaps and checks it against the word-list model.
    task automatic run_load(input string tag, input logic [15:0] base, input logic [16:0] cnt,
                            input bit intrude);
        int          n;
        int          nb;
        int          bi;
        int          gap_left;
        int          budget;
        int          exp_ready;
        int          acc[$];
        int          w0, d0, r0, b0;
        bit          seen;
        bit          intruded;
        int          start_edge;
        logic [63:0] w;
        logic [15:0] ea;
        logic [15:0] ed;

        n  = int'(cnt);
        nb = (n + 3) / 4;
        exp_ready = 0;
        for (int b = 0; b < nb; b++) exp_ready += gaps[b] + 1;
        w0 = wr_addr.size();
        d0 = done_cyc.size();
        r0 = rdy_cnt;
        b0 = busy_cnt;

        start = 1'b1;
        base_addr = base;
        word_count = cnt;
        tick();
        start = 1'b0;
        base_addr = '0;
        word_count = '0;
        start_edge = cyc;

        bi = 0;
        gap_left = (nb > 0) ? gaps[0] : 0;
        seen = 1'b0;
        intruded = 1'b0;
        budget = 0;
        while (!seen && budget < 500) begin
            if (s_valid) begin
                acc.push_back(cyc);
                bi++;
                s_valid = 1'b0;
                s_data = {$urandom, $urandom};
                if (bi < nb) gap_left = gaps[bi];
            end
            if (done) seen = 1'b1;
            if (s_ready && bi < nb) begin
                if (gap_left == 0) begin
                    s_valid = 1'b1;
                    s_data = beats[bi];
                end else begin
                    gap_left--;
                end
            end
            if (intrude && !intruded && ram_we) begin
                start = 1'b1;
                base_addr = base + 16'h1234;
                word_count = 17'd5;
                intruded = 1'b1;
            end else begin
                start = 1'b0;
                base_addr = '0;
                word_count = '0;
            end
            if (!seen) tick();
            budget++;
        end
        start = 1'b0;
        s_valid = 1'b0;
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        repeat (3) tick();

        chk({tag, "_wr_count"}, 32'(wr_addr.size() - w0), 32'(n));
        for (int i = 0; i < n && (w0 + i) < wr_addr.size(); i++) begin
            w  = beats[i / 4];
            ea = base + 16'(i);
            ed = w[16 * (i % 4) +: 16];
            chk($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[w0 + i]), 32'(ea));
            chk($sformatf("%s_data%0d", tag, i), 32'(wr_data[w0 + i]), 32'(ed));
            if ((i / 4) < acc.size())
                chk($sformatf("%s_cyc%0d", tag, i), 32'(wr_cyc[w0 + i]), 32'(acc[i / 4] + i % 4));
        end
        chk({tag, "_done_cnt"}, 32'(done_cyc.size() - d0), 32'd1);
        if (done_cyc.size() > d0) begin
            if (n == 0)
                chk({tag, "_done_when"}, 32'(done_cyc[d0]), 32'(start_edge));
            else if (wr_cyc.size() > w0)
                chk({tag, "_done_when"}, 32'(done_cyc[d0]), 32'(wr_cyc[wr_cyc.size() - 1] + 1));
        end
        chk({tag, "_ready_cycles"}, 32'(rdy_cnt - r0), 32'(exp_ready));
        chk({tag, "_busy_cycles"}, 32'(busy_cnt - b0), 32'(exp_ready + n));
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        word_count = '0;
        s_valid = 1'b0;
        s_data = '0;
        repeat (3) tick();
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_din", 32'(ram_din), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();

        // Two full beats.
        beats = '{64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005};
        gaps = '{0, 0};
        run_load("full", 16'h0100, 17'd8, 1'b0);

        // Partial final beat: words 7 and 8 must never be written.
        run_load("partial", 16'h0000, 17'd6, 1'b0);

        // Zero count: straight to done, no writes, never busy.
        beats.delete();
        gaps.delete();
        run_load("zero", 16'h1234, 17'd0, 1'b0);

        // Address wrap with the first beat held back ten cycles.
        beats = '{64'h0D0C_0B0A_0908_0706};
        gaps = '{10};
        run_load("wrap", 16'hFFFE, 17'd4, 1'b0);

        // Start pulsed during WRITE must be ignored.
        rand_beats(3);
        run_load("ignore_start", 16'h4000, 17'd11, 1'b1);

        // Reset during the second WRITE cycle.
        begin
            int w0, d0;
            w0 = wr_addr.size();
            d0 = done_cyc.size();
            start = 1'b1;
            base_addr = 16'h0200;
            word_count = 17'd8;
            tick();
            start = 1'b0;
            base_addr = '0;
            word_count = '0;
            s_valid = 1'b1;
            s_data = 64'h0004_0003_0002_0001;
            tick();
            s_valid = 1'b0;
            tick();
            chk("midrst_pre_we", 32'(ram_we), 32'd1);
            rst = 1'b1;
            tick();
            chk("midrst_s_ready", 32'(s_ready), 32'd0);
            chk("midrst_ram_we", 32'(ram_we), 32'd0);
            chk("midrst_ram_en", 32'(ram_en), 32'd0);
            chk("midrst_ram_addr", 32'(ram_addr), 32'd0);
            chk("midrst_ram_din", 32'(ram_din), 32'd0);
            chk("midrst_busy", 32'(busy), 32'd0);
            chk("midrst_done", 32'(done), 32'd0);
            rst = 1'b0;
            repeat (8) tick();
            chk("midrst_writes", 32'(wr_addr.size() - w0), 32'd2);
            chk("midrst_no_done", 32'(done_cyc.size() - d0), 32'd0);
        end
        beats = '{64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005};
        gaps = '{1, 0};
        run_load("after_rst", 16'h0300, 17'd7, 1'b0);

        // Randomized loads.
        for (int t = 0; t < 8; t++) begin
            logic [16:0] c;
            c = 17'($urandom_range(0, 20));
            rand_beats((int'(c) + 3) / 4);
            run_load($sformatf("rnd%0d", t), 16'($urandom), c, 1'($urandom_range(0, 1)));
        end

        chk("ram_en_eq_we", 32'(en_mis), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
